alu_writeback_seq: RTL

- Execute-to-writeback stage directly downstream of the ALU.
- Captures the ALU's Result, Long and ALUFlags with their destination info.
- Sequences writes into the single-write-port register file: one write for normal ops, two consecutive writes for long multiplies (low word, then high word).
- Owns the architectural NZCV flags register and backpressures the execute stage while a long-multiply high word is pending.

---
 rtl/alu_writeback_seq.sv | 120 ++++++++++++
 1 files changed

// File: rtl/alu_writeback_seq.sv
// Execute-to-writeback stage: sequences ALU results into a single-port register file
// and owns NZCV. Optional operand hazard detect is enabled with `define WB_HAZARD_EN.
module alu_writeback_seq #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] result,
    input  logic [DW-1:0] long_res,
    input  logic [3:0]    alu_flags,
    input  logic          long_op,
    input  logic          wr_en,
    input  logic          flag_wr,
    input  logic [AW-1:0] rd_lo,
    input  logic [AW-1:0] rd_hi,
`ifdef WB_HAZARD_EN
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic          hazard,
`endif
    output logic          rf_we,
    output logic [AW-1:0] rf_wa,
    output logic [DW-1:0] rf_wd,
    output logic [3:0]    nzcv,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, WR, WRH} state_t;

    state_t        state, state_next;
    logic [DW-1:0] result_q;
    logic [DW-1:0] long_q;
    logic [3:0]    flags_q;
    logic          long_op_q;
    logic          wr_en_q;
    logic          flag_wr_q;
    logic [AW-1:0] rd_lo_q;
    logic [AW-1:0] rd_hi_q;
    logic          accept;

    assign accept = in_valid & in_ready;
    assign busy   = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            result_q  <= '0;
            long_q    <= '0;
            flags_q   <= '0;
            long_op_q <= 1'b0;
            wr_en_q   <= 1'b0;
            flag_wr_q <= 1'b0;
            rd_lo_q   <= '0;
            rd_hi_q   <= '0;
            nzcv      <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                result_q  <= result;
                long_q    <= long_res;
                flags_q   <= alu_flags;
                long_op_q <= long_op;
                wr_en_q   <= wr_en;
                flag_wr_q <= flag_wr;
                rd_lo_q   <= rd_lo;
                rd_hi_q   <= rd_hi;
            end
            // Flags commit once per op, in its low-word cycle only.
            if (state == WR && flag_wr_q) begin
                nzcv <= flags_q;
            end
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        rf_we      = 1'b0;
        rf_wa      = '0;
        rf_wd      = '0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = WR;
            end
            WR: begin
                rf_we = wr_en_q;
                rf_wa = rd_lo_q;
                rf_wd = result_q;
                if (long_op_q) begin
                    state_next = WRH;
                end else begin
                    in_ready   = 1'b1;
                    state_next = in_valid ? WR : IDLE;
                end
            end
            WRH: begin
                rf_we      = wr_en_q;
                rf_wa      = rd_hi_q;
                rf_wd      = long_q;
                in_ready   = 1'b1;
                state_next = in_valid ? WR : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef WB_HAZARD_EN
    always_comb begin
        hazard = 1'b0;
        if (state == WR && wr_en_q && (ra1 == rd_lo_q || ra2 == rd_lo_q)) hazard = 1'b1;
        if (((state == WR && long_op_q) || state == WRH) && wr_en_q &&
            (ra1 == rd_hi_q || ra2 == rd_hi_q)) hazard = 1'b1;
    end
`endif

endmodule
